mpu_instr_issuer: RTL and testbench

Host-side instruction issuer for the MPU. It accepts decoded instruction fields over a valid/ready handshake and packs each into the 13-bit MPU instruction word. It writes the words into the MPU instruction buffer under `buf_full` backpressure. At end of program it drains the buffer through `IB_ren` until `buf_empty`. It is the write end of the instruction-buffer interface that the MPU decoder reads.

---
 rtl/mpu_instr_issuer.sv | 130 +++++++++++++
 tb/tb_mpu_instr_issuer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_instr_issuer.sv
// Host-side MPU instruction issuer: packs decoded fields into 13-bit words,
// writes them to the instruction buffer, then drains the buffer to empty.
module mpu_instr_issuer #(
  parameter int IW        = 13,
  parameter int MAX_WORDS = 32,
  parameter int CW        = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [2:0]    host_op,
  input  logic [4:0]    host_raddr,
  input  logic [4:0]    host_waddr,
  input  logic          host_last,
  output logic [IW-1:0] in,
  output logic          IB_wen,
  output logic          IB_ren,
  input  logic          buf_full,
  input  logic          buf_empty,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] word_count,
  output logic          err_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_in;
  logic          r_wen;
  logic          r_ren;
  logic          r_last;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_word_count;
  logic          r_err;

  logic          w_accept;
  logic [IW-1:0] w_packed;
  logic [CW-1:0] w_count_inc;
  logic          w_hit_max;

  // The !IB_wen term gives the buffer one cycle to raise buf_full after each write.
  assign host_ready  = (r_state == ST_LOAD) && !buf_full && !r_wen;
  assign w_accept    = host_valid && host_ready;
  assign w_packed    = IW'({host_op, host_raddr, host_waddr});
  assign w_count_inc = r_word_count + {{(CW-1){1'b0}}, 1'b1};
  assign w_hit_max   = (w_count_inc == CW'(MAX_WORDS));

  // Issuer state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_in         <= {IW{1'b0}};
      r_wen        <= 1'b0;
      r_ren        <= 1'b0;
      r_last       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_word_count <= {CW{1'b0}};
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_LOAD;
            r_busy       <= 1'b1;
            r_word_count <= {CW{1'b0}};
            r_err        <= 1'b0;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (r_wen) begin
            r_wen        <= 1'b0;
            r_word_count <= w_count_inc;
            if (r_last || w_hit_max) begin
              r_state <= ST_DRAIN;
              if (!r_last) begin
                r_err <= 1'b1;
              end
            end
          end else if (w_accept) begin
            r_in   <= w_packed;
            r_last <= host_last;
            r_wen  <= 1'b1;
          end
        end
        // First DRAIN cycle leaves IB_ren low as the settle cycle.
        ST_DRAIN: begin
          if (buf_empty) begin
            r_ren   <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_ren <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_wen   <= 1'b0;
          r_ren   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in           = r_in;
  assign IB_wen       = r_wen;
  assign IB_ren       = r_ren;
  assign busy         = r_busy;
  assign done         = r_done;
  assign word_count   = r_word_count;
  assign err_overflow = r_err;

endmodule

// File: tb/tb_mpu_instr_issuer.sv
// Directed bench for mpu_instr_issuer: table of packed-word vectors plus
// hand-written sequences for backpressure, overflow, reset and drain timing.
module tb_mpu_instr_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [2:0]  host_op = 3'd0;
  logic [4:0]  host_raddr = 5'd0;
  logic [4:0]  host_waddr = 5'd0;
  logic        host_last = 1'b0;
  logic [12:0] in;
  logic        IB_wen;
  logic        IB_ren;
  logic        buf_full = 1'b0;
  logic        buf_empty = 1'b1;
  logic        busy;
  logic        done;
  logic [5:0]  word_count;
  logic        err_overflow;

  int checks = 0;
  int errors = 0;
  int wen_pulses = 0;
  int wen_base = 0;

  mpu_instr_issuer #(.IW(13), .MAX_WORDS(32), .CW(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_op(host_op), .host_raddr(host_raddr), .host_waddr(host_waddr),
    .host_last(host_last), .in(in), .IB_wen(IB_wen), .IB_ren(IB_ren),
    .buf_full(buf_full), .buf_empty(buf_empty), .busy(busy), .done(done),
    .word_count(word_count), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (IB_wen) wen_pulses <= wen_pulses + 1;
  end

  typedef struct {
    bit          first;
    logic [2:0]  op;
    logic [4:0]  raddr;
    logic [4:0]  waddr;
    bit          last;
    int          stall;
    logic [12:0] exp_in;
    int          n_ren;
    int          exp_count;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {7'd0, in, IB_wen, IB_ren, host_ready, busy, done, word_count, err_overflow}, 32'd0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    wen_base = wen_pulses;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_count_clr", word_count, 0);
    check("start_err_clr", err_overflow, 0);
    check("start_ready", host_ready, 1);
  endtask

  task automatic send(input vec_t v);
    int n;
    @(negedge clk);
    host_op = v.op; host_raddr = v.raddr; host_waddr = v.waddr;
    host_last = v.last; host_valid = 1'b1;
    for (int k = 0; k < v.stall; k++) begin
      buf_full = 1'b1;
      #1;
      check("stall_ready", host_ready, 0);
      check("stall_wen", IB_wen, 0);
      @(negedge clk);
    end
    buf_full = 1'b0;
    #1;
    n = 0;
    while (!host_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_wait", (n < 20), 1);
    @(negedge clk);
    host_valid = 1'b0;
    host_last = 1'b0;
    check("write_wen", IB_wen, 1);
    check("write_word", in, v.exp_in);
    check("write_ready_low", host_ready, 0);
  endtask

  // Entered at the negedge inside the final IB_wen cycle.
  task automatic drain_run(input int n_ren, input int exp_count, input bit exp_err, input bit poke);
    int ren_n, done_n, done_cyc;
    ren_n = 0; done_n = 0; done_cyc = -1;
    buf_empty = (n_ren == 0);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (poke) start = (cyc == 1);
      if (cyc == 1) begin
        check("settle_ren", IB_ren, 0);
        check("drain_busy", busy, 1);
        check("drain_wen", IB_wen, 0);
      end
      if (IB_ren) ren_n++;
      if (ren_n >= n_ren) buf_empty = 1'b1;
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
        check("done_busy_low", busy, 0);
      end
    end
    start = 1'b0;
    check("ren_cycles", ren_n, n_ren);
    check("done_pulses", done_n, 1);
    check("done_latency", done_cyc, n_ren + 3);
    check("final_count", word_count, exp_count);
    check("final_err", err_overflow, exp_err);
    check("wen_pulses", wen_pulses - wen_base, exp_count);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{1'b1, 3'd5, 5'd10, 5'd5,  1'b0, 0, 13'h1545, 0, 0};
    tbl[1] = '{1'b0, 3'd1, 5'd16, 5'd1,  1'b0, 0, 13'h0601, 0, 0};
    tbl[2] = '{1'b0, 3'd2, 5'd3,  5'd17, 1'b1, 0, 13'h0871, 3, 3};
    tbl[3] = '{1'b1, 3'd7, 5'd31, 5'd31, 1'b0, 0, 13'h1FFF, 0, 0};
    tbl[4] = '{1'b0, 3'd4, 5'd1,  5'd30, 1'b0, 5, 13'h103E, 0, 0};
    tbl[5] = '{1'b0, 3'd3, 5'd8,  5'd8,  1'b0, 0, 13'h0D08, 0, 0};
    tbl[6] = '{1'b0, 3'd6, 5'd21, 5'd10, 1'b0, 2, 13'h1AAA, 0, 0};
    tbl[7] = '{1'b0, 3'd0, 5'd0,  5'd1,  1'b1, 0, 13'h0001, 1, 5};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset_outputs");
    rst_n = 1'b1;

    // host_valid in IDLE must not handshake or write
    wen_base = wen_pulses;
    host_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_ready", host_ready, 0);
      check("idle_busy", busy, 0);
    end
    host_valid = 1'b0;
    check("idle_no_write", wen_pulses - wen_base, 0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].first) do_start();
      send(tbl[i]);
      if (tbl[i].last) drain_run(tbl[i].n_ren, tbl[i].exp_count, 1'b0, (i == 2));
    end

    // 32 words without host_last: forced drain and sticky overflow
    do_start();
    for (int i = 0; i < 32; i++) begin
      v.first = 1'b0; v.op = 3'(i); v.raddr = 5'(i); v.waddr = 5'(31 - i);
      v.last = 1'b0; v.stall = 0; v.n_ren = 0; v.exp_count = 0;
      v.exp_in = {v.op, v.raddr, v.waddr};
      send(v);
      if (i == 9) begin
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_start_count", word_count, 10);
        check("load_start_busy", busy, 1);
        check("load_start_err", err_overflow, 0);
      end
    end
    drain_run(2, 32, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("err_sticky_idle", err_overflow, 1);
    do_start();

    // Reset coinciding with an acceptance discards the word
    @(negedge clk);
    host_op = 3'd6; host_raddr = 5'd2; host_waddr = 5'd9; host_valid = 1'b1;
    #1;
    check("rst_pre_ready", host_ready, 1);
    wen_base = wen_pulses;
    rst_n = 1'b0;
    @(negedge clk);
    host_valid = 1'b0;
    check_reset_outputs("rst_midload_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_write", IB_wen, 0);
    check("rst_no_pulses", wen_pulses - wen_base, 0);

    // Single word, buffer already empty at end of settle
    do_start();
    v.first = 1'b0; v.op = 3'd3; v.raddr = 5'd17; v.waddr = 5'd4;
    v.last = 1'b1; v.stall = 0; v.exp_in = 13'h0E24; v.n_ren = 0; v.exp_count = 1;
    send(v);
    drain_run(0, 1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
